// File: rtl/match_uart_tx.sv
// Match-result UART transmitter: buffers {left,right} keypoint pairs in a FIFO
// and sends each one as a 10-byte 8N1 packet, followed by a 0x5A byte at end of frame.
module match_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int LVL_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             match_valid,
  input  logic [31:0]      left_keypoint,
  input  logic [31:0]      right_keypoint,
  input  logic             match_done,
  output logic             tx,
  output logic             tx_busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic [7:0]       drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  function automatic logic [7:0] xor_bytes(input logic [63:0] d);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ d[8*i +: 8];
    end
    return acc;
  endfunction

  function automatic logic [7:0] pkt_byte(input logic is_eof, input logic [3:0] idx,
                                          input logic [63:0] d, input logic [7:0] chk);
    logic [7:0] b;
    case (idx)
      4'd0:    b = is_eof ? 8'h5A : 8'hA5;
      4'd1:    b = d[63:56];
      4'd2:    b = d[55:48];
      4'd3:    b = d[47:40];
      4'd4:    b = d[39:32];
      4'd5:    b = d[31:24];
      4'd6:    b = d[23:16];
      4'd7:    b = d[15:8];
      4'd8:    b = d[7:0];
      4'd9:    b = chk;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  state_t             r_state;
  logic               r_tx;
  logic [63:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [7:0]         r_drop;
  logic               r_eof_pend;
  logic               r_is_eof;
  logic [63:0]        r_data;
  logic [7:0]         r_chk;
  logic [3:0]         r_byte_idx;
  logic [2:0]         r_bit_idx;
  logic [CNT_W-1:0]   r_clk_cnt;

  logic               w_empty;
  logic               w_full;
  logic               w_bit_end;
  logic               w_last_byte;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_eof_take;
  logic [7:0]         w_cur_byte;

  assign w_empty     = (r_level == {LVL_W{1'b0}});
  assign w_full      = (r_level == FULL_LVL);
  assign w_bit_end   = (r_clk_cnt == CNT_MAX);
  assign w_last_byte = r_is_eof ? (r_byte_idx == 4'd0) : (r_byte_idx == 4'd9);
  // The head leaves the FIFO either from IDLE or straight out of the last stop bit.
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) ||
                       ((r_state == ST_STOP) && w_bit_end && w_last_byte));
  assign w_push      = match_valid && (!w_full || w_pop);
  assign w_drop      = match_valid && w_full && !w_pop;
  assign w_eof_take  = (r_state == ST_IDLE) && w_empty && r_eof_pend;
  assign w_cur_byte  = pkt_byte(r_is_eof, r_byte_idx, r_data, r_chk);

  assign tx         = r_tx;
  assign tx_busy    = (r_state != ST_IDLE);
  assign fifo_level = r_level;
  assign drop_count = r_drop;

  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= {left_keypoint, right_keypoint};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
      r_drop   <= 8'd0;
    end else if (clear) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // tx is driven from the state held during the previous cycle, so every bit still lasts CLKS_PER_BIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_eof_pend <= 1'b0;
      r_is_eof   <= 1'b0;
      r_data     <= 64'd0;
      r_chk      <= 8'd0;
      r_byte_idx <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_clk_cnt  <= {CNT_W{1'b0}};
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_eof_pend <= 1'b0;
      r_is_eof   <= 1'b0;
      r_byte_idx <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_clk_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_eof_pend <= match_done || (r_eof_pend && !w_eof_take);
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_data   <= r_mem[r_rd_ptr];
            r_is_eof <= 1'b0;
            r_state  <= ST_LOAD;
          end else if (r_eof_pend) begin
            r_is_eof <= 1'b1;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_tx       <= 1'b1;
          r_chk      <= xor_bytes(r_data);
          r_byte_idx <= 4'd0;
          r_clk_cnt  <= {CNT_W{1'b0}};
          r_state    <= ST_START;
        end
        ST_START: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            r_clk_cnt <= {CNT_W{1'b0}};
            r_bit_idx <= 3'd0;
            r_state   <= ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          r_tx <= w_cur_byte[r_bit_idx];
          if (w_bit_end) begin
            r_clk_cnt <= {CNT_W{1'b0}};
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_clk_cnt <= {CNT_W{1'b0}};
            if (!w_last_byte) begin
              r_byte_idx <= r_byte_idx + 4'd1;
              r_state    <= ST_START;
            end else if (!w_empty) begin
              r_data   <= r_mem[r_rd_ptr];
              r_is_eof <= 1'b0;
              r_state  <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_uart_tx.sv
// Randomized bench for match_uart_tx: a bit-level UART receiver feeds a byte log that is
// compared with packets built from the framing rules and a capacity-based FIFO model.
`timescale 1ns/1ps
module tb_match_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int LW = 3;
  localparam int BYTE_T = 10 * CPB;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, match_valid = 1'b0, match_done = 1'b0;
  logic [31:0] lk = 32'd0, rk = 32'd0;
  logic tx, tx_busy;
  logic [LW-1:0] fifo_level;
  logic [7:0] drop_count;

  match_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .match_valid(match_valid),
    .left_keypoint(lk), .right_keypoint(rk), .match_done(match_done),
    .tx(tx), .tx_busy(tx_busy), .fifo_level(fifo_level), .drop_count(drop_count));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0, exp_drop = 0, peak = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_stop[$];
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART receiver: samples mid-bit on the falling clock edge, aborts on reset/clear.
  initial begin : rx_mon
    bit act;
    int cnt, t0, j;
    logic [7:0] sh;
    act = 1'b0; cnt = 0; t0 = 0; sh = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || clear) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1; cnt = 0; t0 = cyc; sh = 8'd0;
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          j = cnt / CPB;
          if (j >= 1 && j <= 8) sh[j-1] = tx;
          else if (j == 9) begin
            rx_q.push_back(sh); rx_t.push_back(t0); rx_stop.push_back(tx);
            act = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add_pkt(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] d;
    logic [7:0] c, b;
    d = {l, r}; c = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      b = d[8*i +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endfunction

  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic done);
    match_valid = 1'b1; lk = l; rk = r; match_done = done;
    step();
    match_valid = 1'b0; match_done = 1'b0;
  endtask

  task automatic wait_rx(input int base, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_q.size() < base + n && k < budget) begin
      step();
      k++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    check_eq({tag, "_rx_timeout"}, 64'(rx_q.size() >= base + n), 64'd1);
  endtask

  task automatic cmp_rx(input int base, input int n_exp, input string tag);
    for (int i = 0; i < n_exp; i++) begin
      if (base + i < rx_q.size()) begin
        check_eq($sformatf("%s_byte%0d", tag, i), 64'(rx_q[base+i]), 64'(exp_q[i]));
        check_eq($sformatf("%s_stop%0d", tag, i), 64'(rx_stop[base+i]), 64'd1);
      end
    end
    check_eq({tag, "_count"}, 64'(rx_q.size() - base), 64'(n_exp));
  endtask

  task automatic burst(input int n, input string tag);
    int base, kept;
    logic [31:0] l, r;
    base = rx_q.size();
    kept = (n < DEPTH + 1) ? n : DEPTH + 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      l = $urandom; r = $urandom;
      if (i < kept) add_pkt(l, r);
      send(l, r, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end
    exp_drop = exp_drop + n - kept;
    if (exp_drop > 255) exp_drop = 255;
    wait_rx(base, 10 * kept, 450 * kept + 200, tag);
    repeat (2 * BYTE_T) step();
    cmp_rx(base, 10 * kept, tag);
    check_eq({tag, "_drop"}, 64'(drop_count), 64'(exp_drop));
    check_eq({tag, "_busy_end"}, 64'(tx_busy), 64'd0);
  endtask

  initial begin
    int base, t_drive;
    logic [31:0] l, r;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", 64'(tx), 64'd1);
    check_eq("rst_busy", 64'(tx_busy), 64'd0);
    check_eq("rst_level", 64'(fifo_level), 64'd0);
    check_eq("rst_drop", 64'(drop_count), 64'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // T1: fixed packet, latency and duration
    base = rx_q.size(); exp_q.delete();
    add_pkt(32'h00120034, 32'h00560078);
    check_eq("t1_chk_model", 64'(exp_q[9]), 64'h08);
    t_drive = cyc;
    send(32'h00120034, 32'h00560078, 1'b0);
    check_eq("t1_level_visible", 64'(fifo_level), 64'd1);
    step();
    check_eq("t1_level_popped", 64'(fifo_level), 64'd0);
    check_eq("t1_busy", 64'(tx_busy), 64'd1);
    wait_rx(base, 10, 600, "t1");
    repeat (2 * BYTE_T) step();
    cmp_rx(base, 10, "t1");
    if (rx_q.size() >= base + 10) begin
      check_eq("t1_start_latency", 64'(rx_t[base] - t_drive), 64'd4);
      check_eq("t1_span", 64'(rx_t[base+9] - rx_t[base]), 64'(9 * BYTE_T));
    end
    check_eq("t1_busy_end", 64'(tx_busy), 64'd0);

    // T2: three back-to-back strobes
    base = rx_q.size(); exp_q.delete(); peak = 0;
    for (int i = 0; i < 3; i++) begin
      l = $urandom; r = $urandom;
      add_pkt(l, r);
      send(l, r, 1'b0);
    end
    wait_rx(base, 30, 1500, "t2");
    repeat (2 * BYTE_T) step();
    cmp_rx(base, 30, "t2");
    check_eq("t2_peak_level", 64'(peak), 64'd2);
    if (rx_q.size() >= base + 30) begin
      check_eq("t2_intra_gap", 64'(rx_t[base+1] - rx_t[base]), 64'(BYTE_T));
      check_eq("t2_pkt_gap1", 64'(rx_t[base+10] - rx_t[base+9]), 64'(BYTE_T + 1));
      check_eq("t2_pkt_gap2", 64'(rx_t[base+20] - rx_t[base+19]), 64'(BYTE_T + 1));
    end

    // T3: overflow of a 4-deep FIFO
    burst(8, "t3");

    // T4: EOF ordering and collapse
    base = rx_q.size(); exp_q.delete();
    l = $urandom; r = $urandom; add_pkt(l, r); send(l, r, 1'b0);
    step(); step();
    l = $urandom; r = $urandom; add_pkt(l, r); send(l, r, 1'b1);
    exp_q.push_back(8'h5A);
    repeat (150) step();
    match_done = 1'b1; step(); match_done = 1'b0;
    wait_rx(base, 21, 1200, "t4");
    repeat (3 * BYTE_T) step();
    cmp_rx(base, 21, "t4");

    // Randomized bursts
    for (int it = 0; it < 3; it++) burst($urandom_range(1, 7), $sformatf("rnd%0d", it));

    // T6: clear mid-packet with two entries queued
    base = rx_q.size(); exp_q.delete();
    l = $urandom; r = $urandom;
    exp_q.push_back(8'hA5); exp_q.push_back(l[31:24]);
    send(l, r, 1'b0);
    send($urandom, $urandom, 1'b0);
    send($urandom, $urandom, 1'b0);
    repeat (100) step();
    clear = 1'b1; match_valid = 1'b1; lk = $urandom; rk = $urandom;
    step();
    clear = 1'b0; match_valid = 1'b0;
    check_eq("t6_tx", 64'(tx), 64'd1);
    check_eq("t6_level", 64'(fifo_level), 64'd0);
    check_eq("t6_busy", 64'(tx_busy), 64'd0);
    check_eq("t6_drop_held", 64'(drop_count), 64'(exp_drop));
    repeat (500) step();
    cmp_rx(base, 2, "t6");
    check_eq("t6_level_end", 64'(fifo_level), 64'd0);
    check_eq("t6_busy_end", 64'(tx_busy), 64'd0);

    // T5: asynchronous reset during a data bit of byte 4
    base = rx_q.size(); exp_q.delete();
    l = $urandom & 32'hFFFFFF00; r = $urandom;
    add_pkt(l, r);
    send(l, r, 1'b0);
    wait_rx(base, 4, 400, "t5a");
    repeat (12) step();
    check_eq("t5_tx_before", 64'(tx), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t5_tx_async", 64'(tx), 64'd1);
    check_eq("t5_level", 64'(fifo_level), 64'd0);
    check_eq("t5_drop", 64'(drop_count), 64'd0);
    check_eq("t5_busy", 64'(tx_busy), 64'd0);
    exp_drop = 0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    cmp_rx(base, 4, "t5a");
    base = rx_q.size(); exp_q.delete();
    l = $urandom; r = $urandom; add_pkt(l, r);
    send(l, r, 1'b0);
    wait_rx(base, 10, 600, "t5b");
    repeat (2 * BYTE_T) step();
    cmp_rx(base, 10, "t5b");
    check_eq("t5_drop_end", 64'(drop_count), 64'(exp_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
